unit_slave_regfile: RTL and testbench
=====================================

// Module: unit_slave_regfile
// PURPOSE
// - Downstream peripheral unit behind the unit address decoder. Consumes one bit of
//   sel_en plus the shared wr_rd_d/addr/wr_data bus, and returns ack and rd_data.
// - Six instances (UNIT_IDX 0..5) drive the decoder's ack_in[5:0]. rd_data lines are
//   OR-combined, so every idle instance drives 0 on rd_data_out.
// - Holds a DEPTH x 8 register file. Access latency is programmable so the decoder
//   sees realistic, non-zero wait states.
// PARAMETERS
// - UNIT_IDX     0    which sel_en bit this instance answers (0..NUM_UNITS-1)
// - NUM_UNITS    6    width of the sel_en bus
// - DEPTH        16   registers in the file; power of 2, 2..256
// - WAIT_CYCLES  2    extra cycles between request capture and ack (0..15)
// PORTS
// - clock        in   1   rising-edge clock
// - reset_n      in   1   asynchronous, active-low reset
// - sel_en_in    in   6   unit select from decoder; only bit UNIT_IDX is used
// - wr_rd_d_in   in   1   1 = write, 0 = read
// - addr_in      in   8   register address
// - wr_data_in   in   8   write data
// - ack_out      out  1   one-cycle completion pulse, goes to decoder ack_in[UNIT_IDX]
// - rd_data_out  out  8   read data; valid only while ack_out=1, else 8'h00
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, ack_out=0, rd_data_out=0,
//   all registers=0, wait counter=0.
// - req = sel_en_in[UNIT_IDX]. All other sel bits are ignored, even when several are set.
// - FSM states: IDLE, WAIT, ACK, HOLD.
//   - IDLE: when req=1 at edge t0, capture wr_rd_d, addr, wr_data and load the counter
//     with WAIT_CYCLES. Go to WAIT, or straight to ACK if WAIT_CYCLES=0.
//   - WAIT: decrement the counter each edge; go to ACK when it reaches 1.
//     If req=0 at any edge: abort to IDLE, with no write and no ack.
//   - ACK: ack_out=1 for exactly one cycle, starting at edge t0+WAIT_CYCLES+1.
//     - Write commits at the edge entering ACK.
//     - For a read, rd_data_out = reg[addr] in the same cycle.
//     - Next state is HOLD.
//   - HOLD: wait for req=0, then go to IDLE. A request still held after ack is never
//     re-served. If req falls in the ACK cycle, HOLD exits at the next edge.
// - Address decode:
//   - addr < DEPTH: index = addr[$clog2(DEPTH)-1:0].
//   - addr >= DEPTH: the write is dropped and a read returns 8'h00, but ack is still
//     issued so the decoder never hangs.
// - Captured fields are frozen from the t0 edge onward. Bus changes during WAIT are
//   ignored.
// - Back-to-back requests: the minimum spacing is one idle cycle, because req must be
//   seen low in HOLD.
// - Reset mid-transaction: immediate return to IDLE, ack_out=0 at once, register file
//   cleared, any pending write lost.
// STRUCTURE
// - Shared package unit_slave_pkg holds:
//   - typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} slave_state_e;
//   - localparam DATA_W=8, ADDR_W=8, NUM_UNITS_DEF=6;
//   - localparam RD_OOR_VAL=8'h00.
// - One sub-module, unit_regfile: DEPTH x DATA_W array with
//   - asynchronous read port,
//   - synchronous write port with we/waddr/wdata,
//   - async active-low clear.
// - Top level keeps the FSM, wait counter, capture registers and address-range check.
// TESTING
// - Write, then read:
//   - WAIT_CYCLES=2: sel_en=6'b000001, wr=1, addr=3, data=8'hA5 -> ack at t0+3 for
//     one cycle.
//   - Then a read of addr 3 -> rd_data_out=8'hA5 with ack.
// - Foreign select: UNIT_IDX=2, sel_en=6'b000001 held 10 cycles -> ack_out stays 0,
//   rd_data_out stays 0.
// - Abort: sel drops one cycle into WAIT on a write of 8'h3C to addr 5 -> no ack;
//   a later read of addr 5 returns 8'h00.
// - Out of range, DEPTH=16:
//   - write addr 8'h20 -> ack issued, no register changes;
//   - read addr 8'h20 -> ack with rd_data_out=8'h00.
// - Held select: WAIT_CYCLES=0, sel held 6 cycles -> exactly one ack, at t0+1.
//   After sel drops and rises again, a second ack follows.
// - Reset during WAIT: reset_n low mid-wait -> ack_out=0 immediately. After release,
//   a read of a previously written register returns 8'h00.

Source files
------------

// File: rtl/unit_slave_pkg.sv
// Shared types and constants for the unit slave register file.
package unit_slave_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned NUM_UNITS_DEF = 6;
  localparam int unsigned CNT_W         = 4;

  localparam logic [DATA_W-1:0] RD_OOR_VAL = 8'h00;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} slave_state_e;

  // Request fields frozen at capture time.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slave_req_t;

endpackage

// File: rtl/unit_regfile.sv
// DEPTH x DATA_W register array: async read, sync write, async active-low clear.
module unit_regfile
  import unit_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/unit_slave_regfile.sv
// Decoder-facing slave: captures a request, waits WAIT_CYCLES, then acks once
// and holds until the select is released.
module unit_slave_regfile
  import unit_slave_pkg::*;
#(
  parameter int unsigned UNIT_IDX    = 0,
  parameter int unsigned NUM_UNITS   = NUM_UNITS_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] sel_en_in,
  input  logic                 wr_rd_d_in,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [DATA_W-1:0]    wr_data_in,
  output logic                 ack_out,
  output logic [DATA_W-1:0]    rd_data_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  slave_state_e      r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  slave_req_t        r_req;
  logic              w_req;
  logic              w_capture;
  logic              w_we;
  logic              w_in_range;
  logic              w_ack_d;
  logic [DATA_W-1:0] w_rd_d;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_req      = sel_en_in[UNIT_IDX];
  assign w_in_range = CMP_W'(r_req.addr) < CMP_W'(DEPTH);
  assign w_unused   = ^sel_en_in;

  unit_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (r_req.addr[IDX_W-1:0]),
    .i_wdata   (r_req.data),
    .i_raddr   (r_req.addr[IDX_W-1:0]),
    .o_rdata_c (w_rdata)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_we         = 1'b0;
    w_ack_d      = 1'b0;
    w_rd_d       = RD_OOR_VAL;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_capture    = 1'b1;
          w_cnt_next   = WAIT_INIT;
          w_state_next = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = ACK;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ACK: begin
        w_state_next = HOLD;
        w_ack_d      = 1'b1;
        w_we         = r_req.wr && w_in_range;
        if (!r_req.wr && w_in_range) begin
          w_rd_d = w_rdata;
        end
      end
      HOLD: begin
        if (!w_req) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      ack_out     <= 1'b0;
      rd_data_out <= RD_OOR_VAL;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      ack_out     <= w_ack_d;
      rd_data_out <= w_rd_d;
    end
  end

  // Request fields are frozen at the capture edge; later bus activity is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req <= '0;
    end else if (w_capture) begin
      r_req <= '{wr: wr_rd_d_in, addr: addr_in, data: wr_data_in};
    end
  end

endmodule

// File: tb/tb_unit_slave_regfile.sv
// Bench for unit_slave_regfile: three instances on one shared bus, checked
// against per-unit memory arrays and a fixed ack-latency rule.
module tb_unit_slave_regfile;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] sel;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [2:0] ack;
  logic [7:0] rd [3];

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] model [3][16];

  always #5 clock = ~clock;

  unit_slave_regfile #(.UNIT_IDX(0), .NUM_UNITS(6), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .sel_en_in(sel), .wr_rd_d_in(wr),
    .addr_in(addr), .wr_data_in(wdata), .ack_out(ack[0]), .rd_data_out(rd[0]));

  unit_slave_regfile #(.UNIT_IDX(2), .NUM_UNITS(6), .DEPTH(16), .WAIT_CYCLES(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .sel_en_in(sel), .wr_rd_d_in(wr),
    .addr_in(addr), .wr_data_in(wdata), .ack_out(ack[1]), .rd_data_out(rd[1]));

  unit_slave_regfile #(.UNIT_IDX(3), .NUM_UNITS(6), .DEPTH(16), .WAIT_CYCLES(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .sel_en_in(sel), .wr_rd_d_in(wr),
    .addr_in(addr), .wr_data_in(wdata), .ack_out(ack[2]), .rd_data_out(rd[2]));

  function automatic int wait_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int idx_of(input int u);
    case (u)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One request on unit u; ack must arrive exactly once, wait_of(u)+1 edges after capture.
  task automatic txn(input int u, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input int hold, input logic [7:0] exp_rd, input bit scramble);
    int n_ack = 0;
    int k_ack = -1;
    int bad_foreign = 0;
    int bad_idle = 0;
    logic [7:0] rd_at = 8'h00;
    int last = wait_of(u) + 1 + hold;
    sel = 6'(1 << idx_of(u));
    wr = w; addr = a; wdata = d;
    for (int k = 0; k <= last + 3; k++) begin
      tick();
      for (int v = 0; v < 3; v++) begin
        if (v != u && ack[v] !== 1'b0) bad_foreign++;
        if (ack[v] !== 1'b1 && rd[v] !== 8'h00) bad_idle++;
      end
      if (ack[u] === 1'b1) begin
        n_ack++;
        if (k_ack < 0) begin
          k_ack = k;
          rd_at = rd[u];
        end
      end
      if (k == last) sel = 6'b0;
      else if (scramble && sel != 6'b0) {wr, addr, wdata} = 17'($urandom);
    end
    check($sformatf("u%0d a%0h ack_count", u, a), 32'(n_ack), 32'd1);
    check($sformatf("u%0d a%0h ack_latency", u, a), 32'(k_ack), 32'(wait_of(u) + 1));
    if (!w) check($sformatf("u%0d a%0h rd_data", u, a), 32'(rd_at), 32'(exp_rd));
    check($sformatf("u%0d a%0h foreign_ack", u, a), 32'(bad_foreign), 32'd0);
    check($sformatf("u%0d a%0h idle_rd_zero", u, a), 32'(bad_idle), 32'd0);
    if (w && a < 8'd16) model[u][a[3:0]] = d;
  endtask

  typedef struct {
    int         u;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n_ack;
    int n_nz;
    int u;
    logic w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;

    tbl[0]  = '{0, 1'b1, 8'h03, 8'hA5, 0, 8'h00};
    tbl[1]  = '{0, 1'b0, 8'h03, 8'h00, 0, 8'hA5};
    tbl[2]  = '{0, 1'b0, 8'h05, 8'h00, 0, 8'h00};
    tbl[3]  = '{0, 1'b1, 8'h20, 8'h55, 0, 8'h00};
    tbl[4]  = '{0, 1'b0, 8'h20, 8'h00, 0, 8'h00};
    tbl[5]  = '{0, 1'b0, 8'h00, 8'h00, 0, 8'h00};
    tbl[6]  = '{1, 1'b1, 8'h0F, 8'h5A, 1, 8'h00};
    tbl[7]  = '{1, 1'b0, 8'h0F, 8'h00, 0, 8'h5A};
    tbl[8]  = '{0, 1'b0, 8'h0F, 8'h00, 0, 8'h00};
    tbl[9]  = '{2, 1'b1, 8'h07, 8'hC3, 5, 8'h00};
    tbl[10] = '{2, 1'b0, 8'h07, 8'h00, 0, 8'hC3};
    tbl[11] = '{2, 1'b0, 8'h07, 8'h00, 2, 8'hC3};

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) model[i][j] = 8'h00;

    reset_n = 1'b0; sel = 6'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
    #2;
    check("reset ack", 32'(ack), 32'd0);
    for (int v = 0; v < 3; v++) check($sformatf("reset rd u%0d", v), 32'(rd[v]), 32'd0);
    #10 reset_n = 1'b1;
    tick(); tick();

    // Abort one cycle into WAIT: no ack, no write.
    sel = 6'b000001; wr = 1'b1; addr = 8'h05; wdata = 8'h3C;
    tick(); tick();
    sel = 6'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ack[0] !== 1'b0) n_ack++;
    end
    check("abort no_ack", 32'(n_ack), 32'd0);

    for (int i = 0; i < 12; i++)
      txn(tbl[i].u, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold, tbl[i].exp, 1'b0);

    // Only unselected bits high: nobody answers.
    sel = 6'b110010;
    n_ack = 0; n_nz = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack !== 3'b000) n_ack++;
      for (int v = 0; v < 3; v++) if (rd[v] !== 8'h00) n_nz++;
    end
    sel = 6'b0;
    check("foreign_sel ack", 32'(n_ack), 32'd0);
    check("foreign_sel rd", 32'(n_nz), 32'd0);
    tick();

    for (int i = 0; i < 60; i++) begin
      u = int'($urandom_range(0, 2));
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
      d = 8'($urandom);
      exp = (a < 8'd16) ? model[u][a[3:0]] : 8'h00;
      txn(u, w, a, d, int'($urandom_range(0, 3)), exp, 1'b1);
    end

    // Reset while unit A waits and unit C is acking.
    sel = 6'b001001; wr = 1'b1; addr = 8'h09; wdata = 8'h77;
    tick();
    tick();
    check("pre_reset ack_c", 32'(ack[2]), 32'd1);
    check("pre_reset ack_a", 32'(ack[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset ack", 32'(ack), 32'd0);
    check("mid_reset rd_c", 32'(rd[2]), 32'd0);
    sel = 6'b0;
    tick(); tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) model[i][j] = 8'h00;
    tick(); tick();
    txn(0, 1'b0, 8'h09, 8'h00, 0, 8'h00, 1'b0);
    txn(0, 1'b0, 8'h03, 8'h00, 0, 8'h00, 1'b0);
    txn(2, 1'b0, 8'h07, 8'h00, 0, 8'h00, 1'b0);
    txn(1, 1'b1, 8'h02, 8'h99, 0, 8'h00, 1'b0);
    txn(1, 1'b0, 8'h02, 8'h00, 0, 8'h99, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
